// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, legality check, FSM encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // True for the five opcodes the ALU implements; anything else is answered
    // with an error response and never reaches the ALU.
    function automatic logic op_is_legal(input logic [3:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: legal = 1'b1;
            default:                                    legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin picker. Holds the priority pointer; the last grantee
// drops to lowest priority when the owner's transaction completes.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_adv,
    input  logic       i_last,
    output logic [1:0] o_gnt,
    output logic       o_prio
);

    logic r_prio;

    // Priority holder wins if requesting, otherwise the other requester.
    always_comb begin
        // NOTE: defaulting every output first keeps this block free of inferred latches.
        o_gnt = 2'b00;
        if (r_prio == 1'b0) begin
            if (i_req[0])      o_gnt = 2'b01;
            else if (i_req[1]) o_gnt = 2'b10;
        end else begin
            if (i_req[1])      o_gnt = 2'b10;
            else if (i_req[0]) o_gnt = 2'b01;
        end
    end

    // Priority pointer moves to the requester that was not just served.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst) begin
            r_prio <= 1'b0;
        end else if (i_adv) begin
            r_prio <= ~i_last;
        end
    end

    assign o_prio = r_prio;

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates one shared ALU between two requesters. A granted request is
// latched, held on the ALU for ALU_LAT cycles, and its result is returned to
// the owner over a valid/ready response handshake.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W       = 32,
    parameter int ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [W-1:0] req_a0,
    input  logic [W-1:0] req_b0,
    input  logic [W-1:0] req_a1,
    input  logic [W-1:0] req_b1,
    input  logic [3:0]   req_op0,
    input  logic [3:0]   req_op1,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic         rsp_zero,
    output logic         rsp_err,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_ctrl,
    input  logic [W-1:0] alu_result,
    input  logic         alu_zero
);

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(ALU_LAT - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [3:0]      r_op;
    logic            r_owner;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_result;
    logic            r_zero;
    logic            r_err;

    logic [1:0]      w_arb_req;
    logic [1:0]      w_gnt;
    logic            w_prio;
    logic            w_capture;
    logic            w_exec_done;
    logic            w_adv;
    logic            w_sel_owner;
    logic [W-1:0]    w_sel_a;
    logic [W-1:0]    w_sel_b;
    logic [3:0]      w_sel_op;
    logic            w_sel_legal;

    // Arbitration is only offered while idle, so no grant can appear mid-transaction.
    assign w_arb_req = (r_state == IDLE) ? req_valid : 2'b00;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .i_req  (w_arb_req),
        .i_adv  (w_adv),
        .i_last (r_owner),
        .o_gnt  (w_gnt),
        .o_prio (w_prio)
    );

    // Operand mux for the winning requester.
    assign w_sel_owner = w_gnt[1];
    assign w_sel_a     = w_sel_owner ? req_a1  : req_a0;
    assign w_sel_b     = w_sel_owner ? req_b1  : req_b0;
    assign w_sel_op    = w_sel_owner ? req_op1 : req_op0;
    assign w_sel_legal = op_is_legal(w_sel_op);

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake/ALU outputs; ALU inputs are zero outside EXEC.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_exec_done = 1'b0;
        w_adv       = 1'b0;
        req_ready   = 2'b00;
        rsp_valid   = 2'b00;
        alu_a       = '0;
        alu_b       = '0;
        alu_ctrl    = 4'b0000;
        case (r_state)
            IDLE: begin
                req_ready = w_gnt;
                if (w_gnt != 2'b00) begin
                    w_capture   = 1'b1;
                    w_state_nxt = w_sel_legal ? EXEC : RESP;
                end
            end
            EXEC: begin
                alu_a    = r_a;
                alu_b    = r_b;
                alu_ctrl = r_op;
                if (r_cnt == '0) begin
                    w_exec_done = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = r_owner ? 2'b10 : 2'b01;
                if (rsp_ready[r_owner]) begin
                    w_adv       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Request capture, latency countdown and result/flag capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 4'b0000;
            r_owner  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_capture) begin
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_op    <= w_sel_op;
            r_owner <= w_sel_owner;
            r_cnt   <= CNT_INIT;
            if (!w_sel_legal) begin
                r_result <= '0;
                r_zero   <= 1'b0;
                r_err    <= 1'b1;
            end
        end else if (r_state == EXEC) begin
            if (w_exec_done) begin
                r_result <= alu_result;
                r_zero   <= (r_op == ALU_SUB) ? alu_zero : 1'b0;
                r_err    <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;
    assign rsp_err    = r_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU and a response scoreboard.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk;
    logic        rst;

    // Main DUT (ALU_LAT = 1)
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  op0, op1;
    logic [31:0] rsp_result, alu_a, alu_b, alu_result;
    logic        rsp_zero, rsp_err, alu_zero;
    logic [3:0]  alu_ctrl;

    // Second DUT (ALU_LAT = 3)
    logic [1:0]  rv3, ready3, rspv3, rr3;
    logic [31:0] a03, b03;
    logic [3:0]  op03;
    logic [31:0] res3, alu_a3, alu_b3, alu_res3;
    logic        zero3, err3, alu_zero3;
    logic [3:0]  alu_ctrl3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        owner;
        logic [31:0] res;
        logic        zero;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          grant_log[$];
    logic [31:0] exp_res  [2];
    logic        exp_zero [2];
    logic        exp_err  [2];

    alu_arbiter #(.W(32), .ALU_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(a0), .req_b0(b0), .req_a1(a1), .req_b1(b1),
        .req_op0(op0), .req_op1(op1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    alu_arbiter #(.W(32), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(rv3), .req_ready(ready3),
        .req_a0(a03), .req_b0(b03), .req_a1(32'd0), .req_b1(32'd0),
        .req_op0(op03), .req_op1(4'd0),
        .rsp_valid(rspv3), .rsp_ready(rr3),
        .rsp_result(res3), .rsp_zero(zero3), .rsp_err(err3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_ctrl(alu_ctrl3),
        .alu_result(alu_res3), .alu_zero(alu_zero3)
    );

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Behavioural ALUs: zero flag reflects the result for every opcode.
    always_comb begin
        alu_result = alu_f(alu_a, alu_b, alu_ctrl);
        alu_zero   = (alu_result == 32'd0);
        alu_res3   = alu_f(alu_a3, alu_b3, alu_ctrl3);
        alu_zero3  = (alu_res3 == 32'd0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int n = 0; n < budget && sb.size() != 0; n++) begin
            tick();
            mid();
        end
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard: push on every accepted request, pop/compare on every response handshake.
    always @(negedge clk) begin
        if (rst) begin
            check("rsp_onehot", 64'($countones(rsp_valid) <= 1), 64'd1);
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back('{owner: i[0], res: exp_res[i], zero: exp_zero[i], err: exp_err[i]});
                    grant_log.push_back(i);
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        check("sb_owner",  64'(i),          64'(e.owner));
                        check("sb_result", 64'(rsp_result), 64'(e.res));
                        check("sb_zero",   64'(rsp_zero),   64'(e.zero));
                        check("sb_err",    64'(rsp_err),    64'(e.err));
                    end
                end
            end
        end
    end

    initial begin
        logic got;
        rst = 1'b0;
        req_valid = 2'b00; rsp_ready = 2'b11;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = '0; op1 = '0;
        rv3 = 2'b00; rr3 = 2'b11; a03 = '0; b03 = '0; op03 = '0;
        for (int i = 0; i < 2; i++) begin
            exp_res[i] = '0; exp_zero[i] = 1'b0; exp_err[i] = 1'b0;
        end

        // Reset values before any clock edge
        #3;
        check("rst_req_ready",  64'(req_ready),  64'd0);
        check("rst_rsp_valid",  64'(rsp_valid),  64'd0);
        check("rst_rsp_result", 64'(rsp_result), 64'd0);
        check("rst_rsp_zero",   64'(rsp_zero),   64'd0);
        check("rst_rsp_err",    64'(rsp_err),    64'd0);
        check("rst_alu_a",      64'(alu_a),      64'd0);
        check("rst_alu_b",      64'(alu_b),      64'd0);
        check("rst_alu_ctrl",   64'(alu_ctrl),   64'd0);
        tick();
        rst = 1'b1;

        // T1: req0 ADD wrap-around
        tick();
        a0 = 32'hFFFF_FFFF; b0 = 32'h0000_0002; op0 = ALU_ADD;
        exp_res[0] = 32'h0000_0001; exp_zero[0] = 1'b0; exp_err[0] = 1'b0;
        req_valid = 2'b01;
        mid();
        check("t1_ready_c0", 64'(req_ready), 64'd1);
        tick();
        req_valid = 2'b00;
        mid();
        check("t1_alu_ctrl_c1", 64'(alu_ctrl), 64'(ALU_ADD));
        check("t1_alu_a_c1",    64'(alu_a),    64'hFFFF_FFFF);
        check("t1_rspv_c1",     64'(rsp_valid), 64'd0);
        tick();
        mid();
        check("t1_rspv_c2",   64'(rsp_valid),  64'd1);
        check("t1_result_c2", 64'(rsp_result), 64'd1);
        check("t1_zero_c2",   64'(rsp_zero),   64'd0);
        check("t1_err_c2",    64'(rsp_err),    64'd0);
        check("t1_alu_ctrl_c2", 64'(alu_ctrl), 64'd0);
        tick();
        mid();
        check("t1_rspv_c3", 64'(rsp_valid), 64'd0);

        // Fresh reset so priority starts at requester 0
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        grant_log.delete();

        // T2: constant contention, SUB 5-5 on req0 and SLT 3<7 on req1
        tick();
        a0 = 32'd5; b0 = 32'd5; op0 = ALU_SUB;
        exp_res[0] = 32'd0; exp_zero[0] = 1'b1; exp_err[0] = 1'b0;
        a1 = 32'd3; b1 = 32'd7; op1 = ALU_SLT;
        exp_res[1] = 32'd1; exp_zero[1] = 1'b0; exp_err[1] = 1'b0;
        req_valid = 2'b11;
        for (int n = 0; n < 40 && grant_log.size() < 4; n++) begin
            mid();
            tick();
        end
        req_valid = 2'b00;
        check("t2_grant_count", 64'(grant_log.size() >= 4), 64'd1);
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size()) check("t2_grant_order", 64'(grant_log[i]), 64'(i % 2));
        end
        wait_drain("t2_drain", 20);

        // T3: illegal opcode on req1
        tick();
        a1 = 32'h1234_5678; b1 = 32'h9ABC_DEF0; op1 = 4'b0101;
        exp_res[1] = 32'd0; exp_zero[1] = 1'b0; exp_err[1] = 1'b1;
        req_valid = 2'b10;
        mid();
        check("t3_ready",        64'(req_ready), 64'd2);
        check("t3_alu_ctrl_acc", 64'(alu_ctrl),  64'd0);
        tick();
        req_valid = 2'b00;
        mid();
        check("t3_rspv",         64'(rsp_valid),  64'd2);
        check("t3_err",          64'(rsp_err),    64'd1);
        check("t3_result",       64'(rsp_result), 64'd0);
        check("t3_zero",         64'(rsp_zero),   64'd0);
        check("t3_alu_ctrl_rsp", 64'(alu_ctrl),   64'd0);
        tick();
        mid();
        check("t3_rspv_done", 64'(rsp_valid), 64'd0);

        // T4: response stall on req0 with req1 pending
        tick();
        rsp_ready = 2'b10;
        a0 = 32'hFF00_FF00; b0 = 32'h0FF0_0FF0; op0 = ALU_AND;
        exp_res[0] = 32'h0F00_0F00; exp_zero[0] = 1'b0; exp_err[0] = 1'b0;
        req_valid = 2'b01;
        mid();
        check("t4_ready0", 64'(req_ready), 64'd1);
        tick();
        a1 = 32'd10; b1 = 32'd20; op1 = ALU_ADD;
        exp_res[1] = 32'd30; exp_zero[1] = 1'b0; exp_err[1] = 1'b0;
        req_valid = 2'b10;
        mid();
        check("t4_exec_ready", 64'(req_ready), 64'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            mid();
            check("t4_stall_rspv",   64'(rsp_valid),  64'd1);
            check("t4_stall_result", 64'(rsp_result), 64'h0F00_0F00);
            check("t4_stall_ready",  64'(req_ready),  64'd0);
        end
        tick();
        rsp_ready = 2'b11;
        mid();
        check("t4_rspv_hs", 64'(rsp_valid), 64'd1);
        tick();
        mid();
        check("t4_req1_grant", 64'(req_ready), 64'd2);
        tick();
        req_valid = 2'b00;
        wait_drain("t4_drain", 20);

        // T5: ALU_LAT=3, OR held on the ALU for three cycles
        tick();
        a03 = 32'hF0F0_0000; b03 = 32'h0000_0F0F; op03 = ALU_OR;
        rv3 = 2'b01;
        mid();
        check("t5_ready", 64'(ready3), 64'd1);
        tick();
        rv3 = 2'b00;
        for (int k = 1; k <= 3; k++) begin
            mid();
            check("t5_alu_a",    64'(alu_a3),    64'hF0F0_0000);
            check("t5_alu_b",    64'(alu_b3),    64'h0000_0F0F);
            check("t5_alu_ctrl", 64'(alu_ctrl3), 64'(ALU_OR));
            check("t5_rspv_low", 64'(rspv3),     64'd0);
            tick();
        end
        mid();
        check("t5_rspv",   64'(rspv3),     64'd1);
        check("t5_result", 64'(res3),      64'hF0F0_0F0F);
        check("t5_zero",   64'(zero3),     64'd0);
        check("t5_err",    64'(err3),      64'd0);
        check("t5_alu_idle", 64'(alu_ctrl3), 64'd0);
        tick();
        mid();
        check("t5_rspv_done", 64'(rspv3), 64'd0);

        // T6: move priority to requester 1, then reset mid-EXEC
        tick();
        a0 = 32'd1; b0 = 32'd1; op0 = ALU_ADD;
        exp_res[0] = 32'd2; exp_zero[0] = 1'b0; exp_err[0] = 1'b0;
        req_valid = 2'b01;
        mid();
        check("t6_pre_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 2'b00;
        wait_drain("t6_pre_drain", 20);
        tick();
        a0 = 32'd9; b0 = 32'd9; op0 = ALU_SUB;
        exp_res[0] = 32'd0; exp_zero[0] = 1'b1; exp_err[0] = 1'b0;
        req_valid = 2'b01;
        mid();
        check("t6_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 2'b00;
        mid();
        check("t6_exec_ctrl", 64'(alu_ctrl), 64'(ALU_SUB));
        #1;
        rst = 1'b0;
        #1;
        check("t6_async_alu_a",    64'(alu_a),      64'd0);
        check("t6_async_alu_b",    64'(alu_b),      64'd0);
        check("t6_async_alu_ctrl", 64'(alu_ctrl),   64'd0);
        check("t6_async_rspv",     64'(rsp_valid),  64'd0);
        check("t6_async_ready",    64'(req_ready),  64'd0);
        check("t6_async_result",   64'(rsp_result), 64'd0);
        check("t6_async_zero",     64'(rsp_zero),   64'd0);
        check("t6_async_err",      64'(rsp_err),    64'd0);
        sb.delete();
        tick();
        tick();
        rst = 1'b1;

        tick();
        a0 = 32'd4; b0 = 32'd4; op0 = ALU_AND;
        exp_res[0] = 32'd4; exp_zero[0] = 1'b0; exp_err[0] = 1'b0;
        a1 = 32'd7; b1 = 32'd7; op1 = ALU_SUB;
        exp_res[1] = 32'd0; exp_zero[1] = 1'b1; exp_err[1] = 1'b0;
        req_valid = 2'b11;
        mid();
        check("t6_prio_reset", 64'(req_ready), 64'd1);
        tick();
        req_valid = 2'b10;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            mid();
            if (req_ready == 2'b10) got = 1'b1;
            else tick();
        end
        check("t6_req1_grant", 64'(got), 64'd1);
        tick();
        req_valid = 2'b00;
        wait_drain("t6_drain", 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
